// File: rtl/serial_ha_adder_ctrl.sv
// serial_ha_adder_ctrl: bit-serial adder sequencing one shared half adder, two passes per bit
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_ha_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, PH1, PH2, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic carry_q, carry_d, s1_q, s1_d, c1_q, c1_d, cout_q, cout_d;
  logic ha_x, ha_y, ha_s, ha_c;
  assign ha_x = state_q == PH1 ? a_q[0] : s1_q;
  assign ha_y = state_q == PH1 ? b_q[0] : carry_q;
  half_adder u_ha (.x(ha_x), .y(ha_y), .s(ha_s), .c(ha_c));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      s1_q    <= 1'b0;
      c1_q    <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      s1_q    <= s1_d;
      c1_q    <= c1_d;
      cout_q  <= cout_d;
    end
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    s1_d    = s1_q;
    c1_d    = c1_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: if (start) begin
        a_d     = a;
        b_d     = b;
        carry_d = cin;
        idx_d   = '0;
        state_d = PH1;
      end
      PH1: begin
        s1_d    = ha_s;
        c1_d    = ha_c;
        state_d = PH2;
      end
      PH2: begin
        res_d   = (res_q >> 1) | (WIDTH'(ha_s) << (WIDTH - 1));
        carry_d = c1_q | ha_c;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        idx_d   = idx_q + 1'b1;
        state_d = PH1;
        if (idx_q == IW'(WIDTH - 1)) begin
          sum_d   = res_d;
          cout_d  = carry_d;
          idx_d   = idx_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy = state_q == PH1 || state_q == PH2;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule
